// File: rtl/core_pkg.sv
// Shared encodings for the RV32I/M control pipe: opcodes, ALU op classes,
// PC select codes and the registered EX control bundle.
package core_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_R      = 2'b10;
    localparam logic [1:0] ALUOP_I      = 2'b11;

    localparam logic [1:0] PC_SEL_PLUS4 = 2'b00;
    localparam logic [1:0] PC_SEL_IMM   = 2'b01;
    localparam logic [1:0] PC_SEL_ALU   = 2'b10;

    localparam logic [6:0] FUNCT7_MDU = 7'b0000001;

    typedef struct packed {
        logic       valid;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrc;
        logic [1:0] aluop;
        logic       jal;
        logic       jalr;
        logic       branch_op;
        logic       mdu;
        logic [2:0] funct3;
    } ctrl_t;

endpackage

// File: rtl/core_branch_cond.sv
// Evaluates the RV32I branch condition for the instruction in EX from the
// ALU compare flags; the reserved funct3 codes 010/011 never take.
module core_branch_cond (
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       less,
    input  logic       lessu,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = less;
            3'b101:  taken = !less;
            3'b110:  taken = lessu;
            3'b111:  taken = !lessu;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/core_control_pipe.sv
// RV32I/M control unit: decodes ID into a control bundle, registers it into
// EX, resolves redirects in EX and handles load-use and MDU stalls.
module core_control_pipe
    import core_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int EN_MDU  = 1,
    parameter int MDU_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid_i,
    input  logic [6:0]        id_opcode_i,
    input  logic [2:0]        id_funct3_i,
    input  logic [6:0]        id_funct7_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              ex_zero_i,
    input  logic              ex_less_i,
    input  logic              ex_lessu_i,
    output logic              ex_valid_o,
    output logic              ex_memread_o,
    output logic              ex_memwrite_o,
    output logic              ex_memtoreg_o,
    output logic              ex_regwrite_o,
    output logic              ex_alusrc_o,
    output logic [1:0]        ex_aluop_o,
    output logic              ex_jal_o,
    output logic              ex_jalr_o,
    output logic              ex_branch_op_o,
    output logic              ex_mdu_o,
    output logic [2:0]        ex_funct3_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              stall_o,
    output logic              if_flush_o,
    output logic [1:0]        pc_sel_o,
    output logic              illegal_o
);

    localparam int CNT_W = $clog2(MDU_LAT + 1);

    ctrl_t             dec;
    ctrl_t             ex_q;
    logic [REG_AW-1:0] rd_q;
    logic [CNT_W-1:0]  mdu_cnt;
    logic              known_op;
    logic              rs2_used;
    logic              taken;
    logic              load_use;
    logic              busy;
    logic              ex_load;

    always_comb begin
        dec        = '0;
        known_op   = 1'b1;
        rs2_used   = 1'b0;
        dec.valid  = 1'b1;
        dec.funct3 = id_funct3_i;
        case (id_opcode_i)
            OP_R: begin
                dec.regwrite = 1'b1;
                dec.aluop    = ALUOP_R;
                dec.mdu      = (EN_MDU != 0) && (id_funct7_i == FUNCT7_MDU);
                rs2_used     = 1'b1;
            end
            OP_I: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.aluop    = ALUOP_I;
            end
            OP_LOAD: begin
                dec.memread  = 1'b1;
                dec.memtoreg = 1'b1;
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
            end
            OP_STORE: begin
                dec.memwrite = 1'b1;
                dec.alusrc   = 1'b1;
                rs2_used     = 1'b1;
            end
            OP_BRANCH: begin
                dec.branch_op = 1'b1;
                dec.aluop     = ALUOP_BRANCH;
                rs2_used      = 1'b1;
            end
            OP_JAL: begin
                dec.regwrite = 1'b1;
                dec.jal      = 1'b1;
            end
            OP_JALR: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.jalr     = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                dec.aluop = ALUOP_ADD;
            end
            default: known_op = 1'b0;
        endcase
    end

    core_branch_cond u_branch_cond (
        .funct3 (ex_q.funct3),
        .zero   (ex_zero_i),
        .less   (ex_less_i),
        .lessu  (ex_lessu_i),
        .taken  (taken)
    );

    always_comb begin
        pc_sel_o = PC_SEL_PLUS4;
        if (ex_q.valid) begin
            if ((ex_q.branch_op && taken) || ex_q.jal) begin
                pc_sel_o = PC_SEL_IMM;
            end else if (ex_q.jalr) begin
                pc_sel_o = PC_SEL_ALU;
            end
        end
    end

    assign if_flush_o = (pc_sel_o != PC_SEL_PLUS4);
    assign load_use   = ex_q.valid && ex_q.memread && (rd_q != '0) && id_valid_i &&
                        ((rd_q == id_rs1_i) || (rs2_used && (rd_q == id_rs2_i)));
    assign busy       = (mdu_cnt != '0);
    assign stall_o    = (load_use || busy) && !if_flush_o;
    assign ex_load    = !if_flush_o && !busy && !load_use && id_valid_i && known_op;

    // Flush beats the MDU hold, which beats the load-use bubble; only a clean
    // ID slot can load a new bundle or report an illegal opcode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            rd_q      <= '0;
            illegal_o <= 1'b0;
            mdu_cnt   <= '0;
        end else begin
            illegal_o <= 1'b0;
            if (if_flush_o) begin
                ex_q <= '0;
                rd_q <= '0;
            end else if (busy) begin
                ex_q <= ex_q;
                rd_q <= rd_q;
            end else if (load_use || !id_valid_i || !known_op) begin
                ex_q      <= '0;
                rd_q      <= '0;
                illegal_o <= !load_use && id_valid_i && !known_op;
            end else begin
                ex_q <= dec;
                rd_q <= id_rd_i;
            end

            if (ex_load && dec.mdu) begin
                mdu_cnt <= CNT_W'(MDU_LAT - 1);
            end else if (busy) begin
                mdu_cnt <= mdu_cnt - CNT_W'(1);
            end
        end
    end

    assign ex_valid_o     = ex_q.valid;
    assign ex_memread_o   = ex_q.memread;
    assign ex_memwrite_o  = ex_q.memwrite;
    assign ex_memtoreg_o  = ex_q.memtoreg;
    assign ex_regwrite_o  = ex_q.regwrite;
    assign ex_alusrc_o    = ex_q.alusrc;
    assign ex_aluop_o     = ex_q.aluop;
    assign ex_jal_o       = ex_q.jal;
    assign ex_jalr_o      = ex_q.jalr;
    assign ex_branch_op_o = ex_q.branch_op;
    assign ex_mdu_o       = ex_q.mdu;
    assign ex_funct3_o    = ex_q.funct3;
    assign ex_rd_o        = rd_q;

endmodule
